// File: rtl/db_req_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | db_req_arbiter: two-requester round-robin front end for the KV DB port    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module db_req_arbiter #(
  parameter int KEY_SIZE  = 96,
  parameter int FLAG_SIZE = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk156,
  input  logic                 eth_rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [KEY_SIZE-1:0]  req0_key,
  input  logic [FLAG_SIZE-1:0] req0_flag,
  output logic                 rsp0_valid,
  output logic [FLAG_SIZE-1:0] rsp0_flag,
  output logic                 rsp0_timeout,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [KEY_SIZE-1:0]  req1_key,
  input  logic [FLAG_SIZE-1:0] req1_flag,
  output logic                 rsp1_valid,
  output logic [FLAG_SIZE-1:0] rsp1_flag,
  output logic                 rsp1_timeout,
  output logic                 db_in_valid,
  output logic [KEY_SIZE-1:0]  db_in_key,
  output logic [FLAG_SIZE-1:0] db_in_flag,
  input  logic                 db_out_valid,
  input  logic [FLAG_SIZE-1:0] db_out_flag,
  output logic                 busy,
  output logic [15:0]          timeout_cnt,
  output logic [15:0]          stray_cnt
);

  localparam logic [15:0] WAIT_TERM = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic                 grant;
  logic                 grant_any;
  logic                 accept;
  logic                 reply_hit;
  logic                 timeout_hit;
  logic                 stray_hit;
  logic                 owner;
  logic                 last_grant;
  logic [KEY_SIZE-1:0]  key_q;
  logic [FLAG_SIZE-1:0] flag_q;
  logic [15:0]          wait_cnt;

  // On contention the requester that did not win last time gets the port.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else begin
      grant = req1_valid;
    end
  end

  always_ff @(posedge clk156) begin
    if (!eth_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    reply_hit   = 1'b0;
    timeout_hit = 1'b0;
    stray_hit   = 1'b0;
    case (state)
      IDLE: begin
        stray_hit = db_out_valid;
        if (grant_any) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        stray_hit = db_out_valid;
        state_nxt = WAIT;
      end
      WAIT: begin
        // A reply on the terminal-count cycle takes priority over the timeout.
        if (db_out_valid) begin
          reply_hit = 1'b1;
          state_nxt = IDLE;
        end else if (wait_cnt == WAIT_TERM) begin
          timeout_hit = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign req0_ready  = accept & ~grant;
  assign req1_ready  = accept & grant;
  assign db_in_valid = (state == ISSUE);
  assign db_in_key   = key_q;
  assign db_in_flag  = flag_q;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk156) begin
    if (!eth_rst_n) begin
      key_q        <= '0;
      flag_q       <= '0;
      owner        <= 1'b0;
      last_grant   <= 1'b1;
      wait_cnt     <= '0;
      rsp0_valid   <= 1'b0;
      rsp0_flag    <= '0;
      rsp0_timeout <= 1'b0;
      rsp1_valid   <= 1'b0;
      rsp1_flag    <= '0;
      rsp1_timeout <= 1'b0;
      timeout_cnt  <= '0;
      stray_cnt    <= '0;
    end else begin
      rsp0_valid   <= 1'b0;
      rsp0_flag    <= '0;
      rsp0_timeout <= 1'b0;
      rsp1_valid   <= 1'b0;
      rsp1_flag    <= '0;
      rsp1_timeout <= 1'b0;

      if (accept) begin
        key_q      <= grant ? req1_key : req0_key;
        flag_q     <= grant ? req1_flag : req0_flag;
        owner      <= grant;
        last_grant <= grant;
      end

      if (state == ISSUE) begin
        wait_cnt <= '0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + 16'd1;
      end

      if (reply_hit || timeout_hit) begin
        if (owner) begin
          rsp1_valid   <= 1'b1;
          rsp1_flag    <= reply_hit ? db_out_flag : '0;
          rsp1_timeout <= timeout_hit;
        end else begin
          rsp0_valid   <= 1'b1;
          rsp0_flag    <= reply_hit ? db_out_flag : '0;
          rsp0_timeout <= timeout_hit;
        end
      end

      if (timeout_hit && (timeout_cnt != 16'hFFFF)) begin
        timeout_cnt <= timeout_cnt + 16'd1;
      end
      if (stray_hit && (stray_cnt != 16'hFFFF)) begin
        stray_cnt <= stray_cnt + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire
